// File: rtl/adder4_arb_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the shared 4-bit adder.
package adder4_arb_pkg;

  typedef enum logic {StEmpty, StFull} arb_state_e;

  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefWidth  = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/Adder4Bit.sv
// Plain 4-bit ripple adder with carry-in/carry-out; the single shared datapath.
module Adder4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_grant
  import adder4_arb_pkg::*;
#(
  parameter int unsigned N   = DefNumReq,
  parameter int unsigned IDW = clog2(DefNumReq)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDW'((32'(ptr) + k) % N);
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder4_arbiter.sv
// Shares one Adder4Bit between NUM_REQ requesters; one grant per cycle into a tagged,
// backpressured response register.
module adder4_arbiter
  import adder4_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id
);

  arb_state_e       state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [ID_W-1:0]  id_q;

  logic             can_accept;
  logic             grant_en;
  logic             accept;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  ptr_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign can_accept = (state_q == StEmpty) || rsp_ready;
  // Grants are suppressed during reset so nothing is handshaken away on a reset edge.
  assign grant_en   = can_accept && !reset;
  assign accept     = |req_ready;

  rr_grant #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_rr_grant (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (grant_en),
    .gnt (req_ready),
    .idx (gnt_idx)
  );

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        op_a   = req_a[i*WIDTH +: WIDTH];
        op_b   = req_b[i*WIDTH +: WIDTH];
        op_cin = req_cin[i];
      end
    end
  end

  Adder4Bit u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign ptr_next = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StEmpty;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      if (accept) begin
        state_q  <= StFull;
        rr_ptr_q <= ptr_next;
        sum_q    <= add_sum;
        cout_q   <= add_cout;
        id_q     <= gnt_idx;
      end else if (state_q == StFull && rsp_ready) begin
        state_q <= StEmpty;
      end
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder4_arbiter.sv
// Directed bench for adder4_arbiter: a per-cycle reference model plus literal spot checks.
module tb_adder4_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_sum;
  logic        rsp_cout;
  logic [1:0]  rsp_id;

  int errors = 0;
  int checks = 0;

  adder4_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input int cin);
    req_a[i*4 +: 4] = 4'(a);
    req_b[i*4 +: 4] = 4'(b);
    req_cin[i]      = cin[0];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: state of the response slot and the round-robin pointer.
  bit m_ok   = 1'b0;
  bit m_full = 1'b0;
  int m_ptr  = 0;
  int m_sum  = 0;
  int m_cout = 0;
  int m_id   = 0;

  always @(negedge clock) begin
    int g;
    int idx;
    int s;
    logic [3:0] exp_rdy;
    g       = -1;
    exp_rdy = '0;
    if (m_ok) begin
      check("model rsp_valid", 32'(rsp_valid), 32'(m_full));
      check("model rsp_sum", 32'(rsp_sum), m_sum);
      check("model rsp_cout", 32'(rsp_cout), m_cout);
      check("model rsp_id", 32'(rsp_id), m_id);
    end
    if (!reset && (!m_full || rsp_ready)) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy = 4'(1 << g);
    check("model req_ready", 32'(req_ready), 32'(exp_rdy));
    if (reset) begin
      m_ok = 1'b1; m_full = 1'b0; m_ptr = 0; m_sum = 0; m_cout = 0; m_id = 0;
    end else if (g >= 0) begin
      s      = int'(req_a[g*4 +: 4]) + int'(req_b[g*4 +: 4]) + int'(req_cin[g]);
      m_sum  = s % 16;
      m_cout = s / 16;
      m_id   = g;
      m_full = 1'b1;
      m_ptr  = (g + 1) % 4;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
  end

  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    for (int i = 0; i < 4; i++) set_op(i, i, 1, 0);

    // Reset with all requesters valid.
    repeat (2) begin
      @(negedge clock);
      check("reset req_ready", 32'(req_ready), 0);
      check("reset rsp_valid", 32'(rsp_valid), 0);
      check("reset rsp_sum", 32'(rsp_sum), 0);
      check("reset rsp_id", 32'(rsp_id), 0);
    end
    step();
    reset = 1'b0;

    // Fairness: continuous requests from everyone.
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("rr grant", 32'(req_ready), 32'(1 << order[k]));
      if (k > 0) begin
        check("rr rsp_id", 32'(rsp_id), order[k-1]);
        check("rr rsp_sum", 32'(rsp_sum), order[k-1] + 1);
        check("rr rsp_valid", 32'(rsp_valid), 1);
      end
    end

    // Single op from requester 2: 3+4+1.
    step();
    req_valid = 4'b0100;
    set_op(2, 3, 4, 1);
    @(negedge clock);
    check("rr last rsp_id", 32'(rsp_id), 1);
    check("single grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    @(negedge clock);
    check("single rsp_valid", 32'(rsp_valid), 1);
    check("single rsp_sum", 32'(rsp_sum), 8);
    check("single rsp_cout", 32'(rsp_cout), 0);
    check("single rsp_id", 32'(rsp_id), 2);

    // Wrap and carry, back to back.
    step();
    req_valid = 4'b0100;
    set_op(2, 15, 1, 0);
    @(negedge clock);
    check("wrap grant", 32'(req_ready), 32'b0100);
    step();
    set_op(2, 15, 15, 1);
    @(negedge clock);
    check("wrap rsp_sum", 32'(rsp_sum), 0);
    check("wrap rsp_cout", 32'(rsp_cout), 1);

    // Backpressure: hold result 15/1 while requester 1 waits.
    step();
    req_valid = 4'b0010;
    set_op(1, 5, 6, 0);
    rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("hold req_ready", 32'(req_ready), 0);
      check("hold rsp_valid", 32'(rsp_valid), 1);
      check("hold rsp_sum", 32'(rsp_sum), 15);
      check("hold rsp_cout", 32'(rsp_cout), 1);
      check("hold rsp_id", 32'(rsp_id), 2);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    check("release grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    @(negedge clock);
    check("release rsp_valid", 32'(rsp_valid), 1);
    check("release rsp_id", 32'(rsp_id), 1);
    check("release rsp_sum", 32'(rsp_sum), 11);

    // Reset mid-operation with rr_ptr at 3 and a held result.
    step();
    req_valid = 4'b0100;
    set_op(2, 1, 1, 0);
    @(negedge clock);
    check("pre-reset grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    @(negedge clock);
    check("pre-reset rsp_valid", 32'(rsp_valid), 1);
    check("pre-reset rsp_id", 32'(rsp_id), 2);
    step();
    reset     = 1'b1;
    req_valid = 4'b1001;
    @(negedge clock);
    check("mid reset req_ready", 32'(req_ready), 0);
    step();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("post-reset rsp_valid", 32'(rsp_valid), 0);
    check("post-reset grant", 32'(req_ready), 32'b0001);
    step();
    @(negedge clock);
    check("post-reset next grant", 32'(req_ready), 32'b1000);
    check("post-reset rsp_id", 32'(rsp_id), 0);
    step();
    req_valid = 4'b0000;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
